// File: rtl/bus_pkg.sv
// Shared bus definitions: default bus geometry and split-controller types.
package bus_pkg;
    localparam int N_MST = 2;
    localparam int N_SLV = 3;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} split_state_t;
    typedef logic [$clog2(N_SLV)-1:0] slv_idx_t;
endpackage

// File: rtl/split_entry.sv
// One split-table entry: remembers which slave split a master, whether that
// slave has signalled ready, and how long the entry has been waiting.
module split_entry #(
    parameter int N_SLV   = 3,
    parameter int SLV_W   = 2,
    parameter int TIMEOUT = 256
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cap,
    input  logic             clr,
    input  logic [SLV_W-1:0] slv_sel,
    input  logic [N_SLV-1:0] spl_ready,
    output logic             valid,
    output logic             valid_nxt,
    output logic             rdy,
    output logic             tmo
);
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [SLV_W-1:0] slv;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rdy_nxt;
    logic             hit;
    logic             waiting;

    always_comb begin
        hit = 1'b0;
        for (int s = 0; s < N_SLV; s++) begin
            if (spl_ready[s] && (slv == SLV_W'(s))) hit = 1'b1;
        end
        hit     = hit && valid;
        waiting = valid && !rdy && !hit;
        // Expire on the edge where the count would reach TIMEOUT-1, so the
        // error pulse lands exactly TIMEOUT cycles after capture.
        tmo       = waiting && !cap && (cnt == CNT_W'(TIMEOUT - 2));
        valid_nxt = valid;
        rdy_nxt   = rdy | hit;
        cnt_nxt   = waiting ? cnt + 1'b1 : cnt;
        if (cap) begin
            valid_nxt = 1'b1;
            rdy_nxt   = 1'b0;
            cnt_nxt   = '0;
        end else if (clr || tmo) begin
            valid_nxt = 1'b0;
            rdy_nxt   = 1'b0;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid <= 1'b0;
            rdy   <= 1'b0;
            cnt   <= '0;
        end else begin
            valid <= valid_nxt;
            rdy   <= rdy_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The slave index is only meaningful while valid, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (cap) slv <= slv_sel;
    end
endmodule

// File: rtl/bus_split_ctrl.sv
// Split-transaction controller: masks split masters from arbitration, requests
// a resume grant once their slave is ready and aborts splits that time out.
module bus_split_ctrl
    import bus_pkg::*;
#(
    parameter int N_MST   = bus_pkg::N_MST,
    parameter int N_SLV   = bus_pkg::N_SLV,
    parameter int TIMEOUT = 256
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_MST-1:0]         B_GRANT,
    input  logic [$clog2(N_SLV)-1:0] B_SLV_SEL,
    input  logic                     B_SPLIT,
    input  logic                     B_UTIL,
    input  logic                     B_DONE,
    input  logic [N_SLV-1:0]         SPL_READY,
    output logic [N_MST-1:0]         SPL_MASK,
    output logic [N_MST-1:0]         SPL_RES_REQ,
    output logic                     B_SPL_RESUME,
    output logic                     SPL_BUSY,
    output logic                     SPL_ERR,
    output logic [N_MST-1:0]         SPL_ERR_MST
);
    localparam int SLV_W = $clog2(N_SLV);
    localparam int MST_W = (N_MST > 1) ? $clog2(N_MST) : 1;

    function automatic logic [N_MST-1:0] onehot(input logic [MST_W-1:0] idx);
        return N_MST'(1) << idx;
    endfunction

    function automatic logic [MST_W-1:0] lowest(input logic [N_MST-1:0] v);
        lowest = '0;
        for (int i = N_MST - 1; i >= 0; i--) begin
            if (v[i]) lowest = MST_W'(i);
        end
    endfunction

    split_state_t     state;
    split_state_t     state_nxt;
    logic [MST_W-1:0] sel;
    logic [MST_W-1:0] sel_nxt;
    logic [N_MST-1:0] valid;
    logic [N_MST-1:0] valid_nxt;
    logic [N_MST-1:0] rdy;
    logic [N_MST-1:0] tmo;
    logic [N_MST-1:0] cap;
    logic [N_MST-1:0] clr;
    logic [N_MST-1:0] cand;
    logic             grant_ok;
    logic             rearm;
    logic             resume_nxt;
    logic             in_resume;

    assign grant_ok  = (B_GRANT != '0) && ((B_GRANT & (B_GRANT - 1'b1)) == '0);
    assign cap       = (B_SPLIT && grant_ok) ? B_GRANT : '0;
    // A master being re-split this cycle is not a resume candidate.
    assign cand      = valid & rdy & ~cap;
    assign rearm     = (cap & onehot(sel)) != '0;
    assign in_resume = (state == S_REQ) || (state == S_WAIT);
    assign SPL_MASK  = valid & ~(in_resume ? onehot(sel) : '0);

    for (genvar m = 0; m < N_MST; m++) begin : g_entry
        split_entry #(
            .N_SLV  (N_SLV),
            .SLV_W  (SLV_W),
            .TIMEOUT(TIMEOUT)
        ) u_entry (
            .CLK      (CLK),
            .RST      (RST),
            .cap      (cap[m]),
            .clr      (clr[m]),
            .slv_sel  (B_SLV_SEL),
            .spl_ready(SPL_READY),
            .valid    (valid[m]),
            .valid_nxt(valid_nxt[m]),
            .rdy      (rdy[m]),
            .tmo      (tmo[m])
        );
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        resume_nxt = 1'b0;
        clr        = '0;
        case (state)
            S_IDLE: begin
                if ((cand != '0) && !B_UTIL) begin
                    state_nxt = S_REQ;
                    sel_nxt   = lowest(cand);
                end
            end
            S_REQ: begin
                if (rearm) begin
                    state_nxt = S_IDLE;
                end else if (B_GRANT == onehot(sel)) begin
                    state_nxt  = S_WAIT;
                    resume_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                if (rearm) begin
                    state_nxt = S_IDLE;
                end else if (B_DONE) begin
                    clr       = onehot(sel);
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            sel          <= '0;
            SPL_RES_REQ  <= '0;
            B_SPL_RESUME <= 1'b0;
            SPL_BUSY     <= 1'b0;
            SPL_ERR      <= 1'b0;
            SPL_ERR_MST  <= '0;
        end else begin
            state        <= state_nxt;
            sel          <= sel_nxt;
            SPL_RES_REQ  <= (state_nxt == S_REQ) ? onehot(sel_nxt) : '0;
            B_SPL_RESUME <= resume_nxt;
            SPL_BUSY     <= |valid_nxt;
            SPL_ERR      <= |tmo;
            if (tmo != '0) SPL_ERR_MST <= onehot(lowest(tmo));
        end
    end
endmodule

// File: tb/tb_bus_split_ctrl.sv
// Directed bench for bus_split_ctrl: a per-cycle vector table plus a few
// hand-written same-cycle and reset sequences.
module tb_bus_split_ctrl;
    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] B_GRANT;
    logic [1:0] B_SLV_SEL;
    logic       B_SPLIT;
    logic       B_UTIL;
    logic       B_DONE;
    logic [2:0] SPL_READY;
    logic [1:0] SPL_MASK;
    logic [1:0] SPL_RES_REQ;
    logic       B_SPL_RESUME;
    logic       SPL_BUSY;
    logic       SPL_ERR;
    logic [1:0] SPL_ERR_MST;

    always #5 CLK = ~CLK;

    bus_split_ctrl #(
        .N_MST  (2),
        .N_SLV  (3),
        .TIMEOUT(8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .B_GRANT     (B_GRANT),
        .B_SLV_SEL   (B_SLV_SEL),
        .B_SPLIT     (B_SPLIT),
        .B_UTIL      (B_UTIL),
        .B_DONE      (B_DONE),
        .SPL_READY   (SPL_READY),
        .SPL_MASK    (SPL_MASK),
        .SPL_RES_REQ (SPL_RES_REQ),
        .B_SPL_RESUME(B_SPL_RESUME),
        .SPL_BUSY    (SPL_BUSY),
        .SPL_ERR     (SPL_ERR),
        .SPL_ERR_MST (SPL_ERR_MST)
    );

    typedef struct {
        logic       rst;
        logic [1:0] grant;
        logic [1:0] sel;
        logic       split;
        logic       util;
        logic       done;
        logic [2:0] ready;
        logic [1:0] mask;
        logic [1:0] req;
        logic       resume;
        logic       busy;
        logic       err;
        logic [1:0] emst;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic [1:0] g, input logic [1:0] s,
                       input logic sp, input logic u, input logic d, input logic [2:0] r,
                       input logic [1:0] m, input logic [1:0] q, input logic res,
                       input logic b, input logic e, input logic [1:0] em);
        vec_t v;
        v.rst = rst; v.grant = g; v.sel = s; v.split = sp; v.util = u; v.done = d;
        v.ready = r; v.mask = m; v.req = q; v.resume = res; v.busy = b; v.err = e;
        v.emst = em;
        tbl.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs read afterwards show the
    // state produced by the previous rising edges.
    task automatic drive(input logic rst, input logic [1:0] g, input logic [1:0] s,
                         input logic sp, input logic u, input logic d, input logic [2:0] r);
        @(negedge CLK);
        RST = rst; B_GRANT = g; B_SLV_SEL = s; B_SPLIT = sp;
        B_UTIL = u; B_DONE = d; SPL_READY = r;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {SPL_MASK, SPL_RES_REQ, B_SPL_RESUME, SPL_BUSY, SPL_ERR, SPL_ERR_MST};
    endfunction

    initial begin
        RST = 1'b1; B_GRANT = '0; B_SLV_SEL = '0; B_SPLIT = 1'b0;
        B_UTIL = 1'b0; B_DONE = 1'b0; SPL_READY = '0;
        repeat (2) @(posedge CLK);

        // Basic split on slave 1 by M0, ready 5 cycles later, resume, done.
        add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        add(0, 2'b01, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        for (int i = 0; i < 4; i++)
            add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b01, 2'b00, 0, 1, 0, 2'b00);
        add(0, 2'b00, 0, 0, 0, 0, 3'b010, 2'b01, 2'b00, 0, 1, 0, 2'b00);
        add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b01, 2'b00, 0, 1, 0, 2'b00);
        add(0, 2'b01, 0, 0, 0, 0, 3'b000, 2'b00, 2'b01, 0, 1, 0, 2'b00);
        add(0, 2'b01, 0, 0, 1, 0, 3'b000, 2'b00, 2'b00, 1, 1, 0, 2'b00);
        add(0, 2'b01, 0, 0, 1, 1, 3'b000, 2'b00, 2'b00, 0, 1, 0, 2'b00);
        add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        // M0 on slave 2, M1 on slave 0, both ready together: M0 first.
        add(0, 2'b01, 2, 1, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        add(0, 2'b10, 0, 1, 0, 0, 3'b000, 2'b01, 2'b00, 0, 1, 0, 2'b00);
        add(0, 2'b00, 0, 0, 0, 0, 3'b101, 2'b11, 2'b00, 0, 1, 0, 2'b00);
        add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b11, 2'b00, 0, 1, 0, 2'b00);
        add(0, 2'b01, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 0, 1, 0, 2'b00);
        add(0, 2'b01, 0, 0, 1, 0, 3'b000, 2'b10, 2'b00, 1, 1, 0, 2'b00);
        add(0, 2'b01, 0, 0, 1, 1, 3'b000, 2'b10, 2'b00, 0, 1, 0, 2'b00);
        add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 0, 1, 0, 2'b00);
        add(0, 2'b10, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 0, 1, 0, 2'b00);
        add(0, 2'b10, 0, 0, 1, 1, 3'b000, 2'b00, 2'b00, 1, 1, 0, 2'b00);
        add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        // Bus busy for 4 cycles after ready holds off the request.
        add(0, 2'b01, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        add(0, 2'b00, 0, 0, 0, 0, 3'b010, 2'b01, 2'b00, 0, 1, 0, 2'b00);
        for (int i = 0; i < 4; i++)
            add(0, 2'b00, 0, 0, 1, 0, 3'b000, 2'b01, 2'b00, 0, 1, 0, 2'b00);
        add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b01, 2'b00, 0, 1, 0, 2'b00);
        add(0, 2'b01, 0, 0, 0, 0, 3'b000, 2'b00, 2'b01, 0, 1, 0, 2'b00);
        add(0, 2'b01, 0, 0, 1, 1, 3'b000, 2'b00, 2'b00, 1, 1, 0, 2'b00);
        add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        // M1 split with no ready: error 8 cycles after capture.
        add(0, 2'b10, 0, 1, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        for (int i = 0; i < 7; i++)
            add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 0, 1, 0, 2'b00);
        add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 1, 2'b10);
        add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b10);
        // Splits with zero and multi-hot grant are ignored.
        add(0, 2'b00, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b10);
        add(0, 2'b11, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b10);
        add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b10);
        add(0, 2'b00, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 2'b10);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].grant, tbl[i].sel, tbl[i].split,
                  tbl[i].util, tbl[i].done, tbl[i].ready);
            check($sformatf("row%0d", i), outs(),
                  {tbl[i].mask, tbl[i].req, tbl[i].resume, tbl[i].busy,
                   tbl[i].err, tbl[i].emst});
        end

        // B_SPLIT and B_DONE together in S_WAIT: the new split is kept.
        drive(0, 2'b01, 2'd1, 1, 0, 0, 3'b000);
        drive(0, 2'b00, 2'd0, 0, 0, 0, 3'b010);
        idle();
        drive(0, 2'b01, 2'd0, 0, 0, 0, 3'b000);
        check("sd_req", 9'(SPL_RES_REQ), 9'(2'b01));
        drive(0, 2'b01, 2'd1, 1, 1, 1, 3'b000);
        check("sd_resume", 9'(B_SPL_RESUME), 9'd1);
        idle();
        check("sd_mask", 9'(SPL_MASK), 9'(2'b01));
        check("sd_busy", 9'(SPL_BUSY), 9'd1);
        idle();
        check("sd_noreq", 9'(SPL_RES_REQ), 9'd0);

        drive(1, 2'b00, 2'd0, 0, 0, 0, 3'b000);
        idle();
        check("rst_clears", outs(), 9'd0);

        // Ready on the terminal-count cycle suppresses the timeout.
        drive(0, 2'b10, 2'd2, 1, 0, 0, 3'b000);
        repeat (6) idle();
        drive(0, 2'b00, 2'd0, 0, 0, 0, 3'b100);
        idle();
        check("tc_noerr", 9'(SPL_ERR), 9'd0);
        check("tc_mask", 9'(SPL_MASK), 9'(2'b10));
        drive(0, 2'b10, 2'd0, 0, 0, 0, 3'b000);
        check("tc_req", 9'(SPL_RES_REQ), 9'(2'b10));
        drive(0, 2'b10, 2'd0, 0, 1, 1, 3'b000);
        check("tc_resume", 9'(B_SPL_RESUME), 9'd1);
        idle();
        check("tc_done", outs(), 9'd0);

        // Reset in S_WAIT with two entries valid.
        drive(0, 2'b01, 2'd0, 1, 0, 0, 3'b000);
        drive(0, 2'b10, 2'd1, 1, 0, 0, 3'b000);
        drive(0, 2'b00, 2'd0, 0, 0, 0, 3'b001);
        idle();
        drive(0, 2'b01, 2'd0, 0, 0, 0, 3'b000);
        check("rw_req", {5'd0, SPL_MASK, SPL_RES_REQ}, {5'd0, 2'b10, 2'b01});
        drive(1, 2'b01, 2'd0, 0, 1, 0, 3'b000);
        check("rw_wait", {7'd0, B_SPL_RESUME, SPL_BUSY}, {7'd0, 1'b1, 1'b1});
        idle();
        check("rw_reset", outs(), 9'd0);
        drive(0, 2'b00, 2'd0, 0, 0, 0, 3'b011);
        idle();
        idle();
        check("rw_noreq", outs(), 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
